alu_div_ctrl: RTL and testbench

ALU_DIV_CTRL -- requirements
Module: alu_div_ctrl

---
 rtl/alu_div_ctrl.sv | 126 ++++++++++++
 tb/tb_alu_div_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_div_ctrl.sv
// Divide-unit controller: accepts div/rem ops from execute, resolves the
// divide-by-zero and signed-overflow cases locally, otherwise sequences the
// iterative divider core and returns a tagged result.
module alu_div_ctrl #(
  parameter int XLEN  = 64,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_op_i,
  input  logic [XLEN-1:0]  req_rs1_i,
  input  logic [XLEN-1:0]  req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             resp_valid_o,
  input  logic             resp_ready_i,
  output logic [XLEN-1:0]  resp_data_o,
  output logic [TAG_W-1:0] resp_tag_o,
  output logic             busy_o,
  output logic             core_valid_o,
  output logic             core_signed_o,
  output logic             core_div32_o,
  output logic [XLEN-1:0]  core_dividend_o,
  output logic [XLEN-1:0]  core_divisor_o,
  input  logic [XLEN-1:0]  core_div_data_i,
  input  logic [XLEN-1:0]  core_rem_data_i,
  input  logic             core_ready_i
);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
  } state_e;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_e            state_q, state_d;
  logic              cnt_q;
  logic [2:0]        op_q;
  logic [XLEN-1:0]   rs1_q, rs2_q, data_q;
  logic [TAG_W-1:0]  tag_q;

  logic              accept, word, div_zero, ovf, special;
  logic [XLEN-1:0]   spec_res, core_res;

  // Word results always carry bit 31 into the upper half.
  function automatic logic [XLEN-1:0] wfix(input logic w, input logic [XLEN-1:0] v);
    return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
  endfunction

  // Special-case detection on the incoming (effective) operands.
  always_comb begin
    word     = req_op_i[2];
    div_zero = word ? (req_rs2_i[31:0] == 32'h0) : (req_rs2_i == '0);
    ovf      = ~req_op_i[0] &
               (word ? (req_rs1_i[31:0] == 32'h8000_0000 && req_rs2_i[31:0] == 32'hFFFF_FFFF)
                     : (req_rs1_i == MIN_NEG && req_rs2_i == '1));
    special  = div_zero | ovf;
    if (div_zero) spec_res = req_op_i[1] ? req_rs1_i : '1;
    else          spec_res = req_op_i[1] ? '0 : req_rs1_i;
    spec_res = wfix(word, spec_res);
    core_res = wfix(op_q[2], op_q[1] ? core_rem_data_i : core_div_data_i);
  end

  assign accept = req_valid_i & req_ready_o;

  // State register and settle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_INIT) cnt_q <= 1'b1;
    end
  end

  // Operand capture at acceptance; result capture from special path or core.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
      tag_q  <= '0;
      data_q <= '0;
    end else if (accept) begin
      op_q  <= req_op_i;
      rs1_q <= req_rs1_i;
      rs2_q <= req_rs2_i;
      tag_q <= req_tag_i;
      if (special) data_q <= spec_res;
    end else if (state_q == S_WAIT && core_ready_i && !flush_i) begin
      data_q <= core_res;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = (state_q == S_IDLE) & ~flush_i;
    busy_o       = (state_q != S_IDLE);
    core_valid_o = (state_q == S_ISSUE);
    resp_valid_o = (state_q == S_DONE);
    case (state_q)
      S_INIT:  if (cnt_q) state_d = S_IDLE;
      S_IDLE:  if (accept) state_d = special ? S_DONE : S_ISSUE;
      S_ISSUE: state_d = flush_i ? S_DRAIN : S_WAIT;
      S_WAIT: begin
        if (flush_i)           state_d = core_ready_i ? S_IDLE : S_DRAIN;
        else if (core_ready_i) state_d = S_DONE;
      end
      S_DONE:  if (flush_i || resp_ready_i) state_d = S_IDLE;
      S_DRAIN: if (core_ready_i) state_d = S_IDLE;
      default: state_d = S_INIT;
    endcase
  end

  assign resp_data_o     = data_q;
  assign resp_tag_o      = tag_q;
  assign core_signed_o   = ~op_q[0];
  assign core_div32_o    = op_q[2];
  assign core_dividend_o = rs1_q;
  assign core_divisor_o  = rs2_q;

endmodule

// File: tb/tb_alu_div_ctrl.sv
// Bench for alu_div_ctrl: a behavioural divider core plus a RISC-V
// divide/remainder reference model; directed and random ops.
module tb_alu_div_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_i = 1'b0, req_ready_o;
  logic [2:0]  req_op_i = '0;
  logic [63:0] req_rs1_i = '0, req_rs2_i = '0;
  logic [4:0]  req_tag_i = '0;
  logic        flush_i = 1'b0;
  logic        resp_valid_o, resp_ready_i = 1'b0;
  logic [63:0] resp_data_o;
  logic [4:0]  resp_tag_o;
  logic        busy_o, core_valid_o, core_signed_o, core_div32_o;
  logic [63:0] core_dividend_o, core_divisor_o;
  logic [63:0] core_div_data_i = '0, core_rem_data_i = '0;
  logic        core_ready_i = 1'b0;

  int errors = 0, checks = 0;
  int cyc = 0, rdy_cyc = 0, cv_cnt = 0, fix_lat = 0;
  logic last_sgn, last_w;

  alu_div_ctrl #(.XLEN(64), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
    .req_rs1_i(req_rs1_i), .req_rs2_i(req_rs2_i), .req_tag_i(req_tag_i),
    .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_data_o(resp_data_o), .resp_tag_o(resp_tag_o), .busy_o(busy_o),
    .core_valid_o(core_valid_o), .core_signed_o(core_signed_o), .core_div32_o(core_div32_o),
    .core_dividend_o(core_dividend_o), .core_divisor_o(core_divisor_o),
    .core_div_data_i(core_div_data_i), .core_rem_data_i(core_rem_data_i),
    .core_ready_i(core_ready_i)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Raw RISC-V divide semantics (word results in low 32 bits).
  function automatic void divcalc(input logic sgn, input logic w, input logic [63:0] a,
                                  input logic [63:0] b, output logic [63:0] q, output logic [63:0] r);
    if (w) begin
      int sa, sb;
      sa = a[31:0]; sb = b[31:0];
      if (b[31:0] == 0) begin q = 64'hFFFF_FFFF; r = {32'h0, a[31:0]}; end
      else if (sgn && sa == 32'h8000_0000 && sb == -1) begin q = {32'h0, a[31:0]}; r = 0; end
      else if (sgn) begin q = {32'h0, 32'(sa / sb)}; r = {32'h0, 32'(sa % sb)}; end
      else begin q = {32'h0, a[31:0] / b[31:0]}; r = {32'h0, a[31:0] % b[31:0]}; end
    end else begin
      longint la, lb;
      la = a; lb = b;
      if (b == 0) begin q = '1; r = a; end
      else if (sgn && a == 64'h8000_0000_0000_0000 && lb == -1) begin q = a; r = 0; end
      else if (sgn) begin q = la / lb; r = la % lb; end
      else begin q = a / b; r = a % b; end
    end
  endfunction

  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [63:0] q, r, v;
    divcalc(~op[0], op[2], a, b, q, r);
    v = op[1] ? r : q;
    return op[2] ? {{32{v[31]}}, v[31:0]} : v;
  endfunction

  function automatic logic is_special(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (op[2])
      return b[31:0] == 0 || (!op[0] && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF);
    return b == 0 || (!op[0] && a == 64'h8000_0000_0000_0000 && b == '1);
  endfunction

  // Behavioural divider core: fixed or random latency, junk upper half on word ops.
  initial begin
    logic pend; int cnt;
    logic [63:0] ma, mb, q, r;
    logic ms, mw;
    pend = 0; cnt = 0;
    forever begin
      @(posedge clk); #1;
      core_ready_i = 1'b0;
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          if (cnt == 0) begin
            chk("core_operands_held", {core_signed_o, core_div32_o, core_dividend_o ^ core_divisor_o},
                {ms, mw, ma ^ mb});
            chk("core_dividend_held", core_dividend_o, ma);
            divcalc(ms, mw, ma, mb, q, r);
            core_div_data_i = mw ? {$urandom(), q[31:0]} : q;
            core_rem_data_i = mw ? {$urandom(), r[31:0]} : r;
            core_ready_i = 1'b1;
            rdy_cyc = cyc;
            pend = 0;
          end else cnt--;
        end
        if (core_valid_o) begin
          cv_cnt++;
          pend = 1;
          cnt = (fix_lat != 0) ? fix_lat : int'($urandom_range(0, 4));
          ma = core_dividend_o; mb = core_divisor_o;
          ms = core_signed_o;   mw = core_div32_o;
          last_sgn = ms; last_w = mw;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [4:0] tag, input int hold);
    logic [63:0] exp; logic sp; int n, cv0;
    exp = ref_res(op, a, b);
    sp  = is_special(op, a, b);
    n = 0;
    while (!req_ready_o && n < 50) begin tick(); n++; end
    chk("req_ready_wait", req_ready_o, 1);
    cv0 = cv_cnt;
    req_valid_i = 1; req_op_i = op; req_rs1_i = a; req_rs2_i = b; req_tag_i = tag;
    tick();
    req_valid_i = 0;
    n = 0;
    while (!resp_valid_o && n < 100) begin tick(); n++; end
    chk("resp_valid_seen", resp_valid_o, 1);
    if (sp) chk("special_latency", n, 0);
    else    chk("core_latency", cyc, rdy_cyc + 1);
    chk("resp_data", resp_data_o, exp);
    chk("resp_tag", resp_tag_o, tag);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", resp_valid_o, 1);
      chk("hold_data", resp_data_o, exp);
      chk("hold_tag", resp_tag_o, tag);
      chk("hold_no_ready", req_ready_o, 0);
    end
    resp_ready_i = 1;
    tick();
    resp_ready_i = 0;
    chk("resp_valid_drop", resp_valid_o, 0);
    chk("core_pulses", cv_cnt - cv0, sp ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] op; logic [63:0] a, b; int n;
    // Reset values
    repeat (3) tick();
    chk("rst_busy", busy_o, 1);
    chk("rst_req_ready", req_ready_o, 0);
    chk("rst_resp_valid", resp_valid_o, 0);
    chk("rst_core_valid", core_valid_o, 0);
    chk("rst_resp_data", resp_data_o, 0);
    chk("rst_resp_tag", resp_tag_o, 0);
    chk("rst_operands", core_dividend_o | core_divisor_o, 0);

    // Request offered across the settle window must not be taken
    req_valid_i = 1; req_op_i = 3'd1; req_rs1_i = 64'd9; req_rs2_i = 0; req_tag_i = 5'd3;
    rst_n = 1;
    tick();
    chk("init_c1_ready", req_ready_o, 0);
    tick();
    chk("init_c2_no_resp", resp_valid_o, 0);
    chk("init_done_ready", req_ready_o, 1);
    req_valid_i = 0;
    tick();
    chk("init_no_accept", busy_o, 0);

    // Directed cases
    run_op(3'd0, -64'sd7, 64'd2, 5'd17, 0);                           // DIV
    run_op(3'd7, 64'h0000_0000_FFFF_FFFF, 64'h10, 5'd4, 1);           // REMUW
    chk("remuw_div32", last_w, 1);
    chk("remuw_signed", last_sgn, 0);
    run_op(3'd1, 64'd1234, 64'd0, 5'd5, 0);                           // DIVU /0
    run_op(3'd2, 64'd5, 64'd0, 5'd6, 0);                              // REM /0
    run_op(3'd4, 64'h8000_0000, 64'hFFFF_FFFF, 5'd7, 0);              // DIVW ovf
    run_op(3'd6, 64'h8000_0000, 64'hFFFF_FFFF, 5'd8, 0);              // REMW ovf
    run_op(3'd0, 64'h8000_0000_0000_0000, '1, 5'd9, 0);               // DIV ovf
    run_op(3'd5, 64'h1234_0000_0000_0000, 64'hABCD_0000_0000_0000, 5'd10, 0); // DIVUW eff /0
    run_op(3'd2, -64'sd7, 64'd2, 5'd11, 10);                          // REM, long hold

    // Flush during WAIT: core drains, no response
    fix_lat = 5;
    req_valid_i = 1; req_op_i = 3'd0; req_rs1_i = 64'd50; req_rs2_i = 64'd3; req_tag_i = 5'd12;
    tick();
    req_valid_i = 0;
    tick();
    flush_i = 1;
    tick();
    flush_i = 0;
    n = 0;
    while (!core_ready_i && n < 20) begin
      chk("drain_busy", busy_o, 1);
      chk("drain_no_resp", resp_valid_o, 0);
      tick(); n++;
    end
    chk("drain_core_ready", core_ready_i, 1);
    tick();
    chk("drain_ready_after", req_ready_o, 1);
    chk("drain_no_resp_after", resp_valid_o, 0);
    fix_lat = 0;
    run_op(3'd0, 64'd100, 64'd7, 5'd13, 0);

    // Reset in the middle of an op: abandoned, no response
    fix_lat = 6;
    req_valid_i = 1; req_op_i = 3'd3; req_rs1_i = 64'd77; req_rs2_i = 64'd5; req_tag_i = 5'd14;
    tick();
    req_valid_i = 0;
    tick();
    rst_n = 0;
    #1;
    chk("midrst_busy", busy_o, 1);
    chk("midrst_resp_valid", resp_valid_o, 0);
    chk("midrst_tag", resp_tag_o, 0);
    tick();
    rst_n = 1;
    tick();
    chk("midrst_init", req_ready_o, 0);
    tick();
    chk("midrst_idle", req_ready_o, 1);
    repeat (8) begin
      tick();
      chk("midrst_no_resp", resp_valid_o, 0);
    end
    fix_lat = 0;

    // Random ops with a bias toward the special cases
    for (int k = 0; k < 40; k++) begin
      op = 3'($urandom_range(0, 7));
      a = {$urandom(), $urandom()};
      b = {$urandom(), $urandom()};
      case ($urandom_range(0, 5))
        0: b = op[2] ? {$urandom(), 32'h0} : 64'h0;
        1: begin
          a = op[2] ? {$urandom(), 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = op[2] ? {$urandom(), 32'hFFFF_FFFF} : '1;
        end
        2: b = 64'($urandom_range(1, 300));
        3: b = -64'($urandom_range(1, 300));
        default: ;
      endcase
      run_op(op, a, b, 5'($urandom()), int'($urandom_range(0, 2)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
